// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the LED pattern controller: modes, FSM states,
// bounce direction and the pattern each mode starts from.
package led_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_OFF    = 2'd0,
      MODE_BLINK  = 2'd1,
      MODE_CHASE  = 2'd2,
      MODE_BOUNCE = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      RUN    = 2'd2,
      PAUSED = 2'd3
   } state_t;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_t;

   localparam logic [7:0] PAT_OFF    = 8'h00;
   localparam logic [7:0] PAT_BLINK  = 8'hFF;
   localparam logic [7:0] PAT_CHASE  = 8'h01;
   localparam logic [7:0] PAT_BOUNCE = 8'h01;
   localparam logic [7:0] PAT_MSB    = 8'h80;
   localparam logic [7:0] PAT_LSB    = 8'h01;

   function automatic logic [7:0] init_pattern(input mode_t mode);
      logic [7:0] pat;
      case (mode)
         MODE_BLINK:  pat = PAT_BLINK;
         MODE_CHASE:  pat = PAT_CHASE;
         MODE_BOUNCE: pat = PAT_BOUNCE;
         default:     pat = PAT_OFF;
      endcase
      return pat;
   endfunction

   // Raw step period before the minimum-of-one clamp applied in the timer.
   function automatic logic [31:0] step_period(input logic [31:0] base, input logic [1:0] speed);
      return base >> speed;
   endfunction

endpackage

// File: rtl/led_pattern_ctrl_if.sv
// Mode/speed command channel into the LED pattern controller (valid/ready).
interface led_pattern_ctrl_if;
   import led_ctrl_pkg::*;

   logic       cmd_valid;
   logic       cmd_ready;
   mode_t      cmd_mode;
   logic [1:0] cmd_speed;

   modport master (
      output cmd_valid,
      output cmd_mode,
      output cmd_speed,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_mode,
      input  cmd_speed,
      output cmd_ready
   );

endinterface

// File: rtl/led_step_timer.sv
// Free-running step counter: flags the cycle in which an animation step is due
// and restarts from zero after it. A zero period is treated as one.
module led_step_timer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] period,
   input  logic        enable,
   input  logic        clear,
   output logic        tick
);

   logic [31:0] count_reg;
   logic [31:0] count_next;
   logic [31:0] period_eff;

   assign period_eff = (period == 32'd0) ? 32'd1 : period;
   assign tick       = enable && (count_reg >= (period_eff - 32'd1));

   always_comb begin
      count_next = count_reg;
      if (clear) begin
         count_next = 32'd0;
      end else if (tick) begin
         count_next = 32'd0;
      end else if (enable) begin
         count_next = count_reg + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_reg <= 32'd0;
      end else begin
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED bank animator: accepts mode/speed commands, steps off/blink/chase/bounce
// patterns at a rate derived from the system clock, and honours a pause level.
module led_pattern_ctrl
   import led_ctrl_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 25_000_000,
   parameter int unsigned STEP_DIV = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   led_pattern_ctrl_if.slave  cmd,
   input  logic               pause,
   output logic [7:0]         leds,
   output logic               step_tick,
   output logic               busy
);

   localparam logic [31:0] BASE = 32'(CLK_FREQ / STEP_DIV);

   state_t      state_reg, state_next;
   mode_t       mode_reg, mode_next;
   logic [1:0]  speed_reg, speed_next;
   dir_t        dir_reg, dir_next;
   logic [7:0]  leds_reg, leds_next;
   logic        tick_reg, tick_next;
   logic        ready_reg, ready_next;
   logic        busy_reg, busy_next;

   logic        accept;
   logic        timer_en;
   logic        timer_clr;
   logic        step_due;
   logic [31:0] period;
   logic [7:0]  chase_next;

   assign accept    = cmd.cmd_valid && ready_reg;
   assign period    = step_period(BASE, speed_reg);
   // A command arriving in the same cycle as a due step wins: the step is suppressed.
   assign timer_en  = (state_reg == RUN) && !pause && !accept;
   assign timer_clr = accept;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_rotate
         assign chase_next[gi] = leds_reg[(gi + 7) % 8];
      end
   endgenerate

   led_step_timer u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .period (period),
      .enable (timer_en),
      .clear  (timer_clr),
      .tick   (step_due)
   );

   always_comb begin
      state_next = state_reg;
      mode_next  = mode_reg;
      speed_next = speed_reg;
      dir_next   = dir_reg;
      leds_next  = leds_reg;
      busy_next  = busy_reg;
      tick_next  = 1'b0;
      ready_next = !accept;

      if (accept) begin
         mode_next  = cmd.cmd_mode;
         speed_next = cmd.cmd_speed;
         dir_next   = DIR_LEFT;
         leds_next  = init_pattern(cmd.cmd_mode);
         busy_next  = (cmd.cmd_mode != MODE_OFF);
         state_next = LOAD;
      end else begin
         case (state_reg)
            IDLE: begin
               leds_next = PAT_OFF;
            end
            LOAD: begin
               if (mode_reg == MODE_OFF) begin
                  state_next = IDLE;
               end else if (pause) begin
                  state_next = PAUSED;
               end else begin
                  state_next = RUN;
               end
            end
            RUN: begin
               if (pause) begin
                  state_next = PAUSED;
               end else if (step_due) begin
                  tick_next = 1'b1;
                  case (mode_reg)
                     MODE_BLINK: leds_next = ~leds_reg;
                     MODE_CHASE: leds_next = chase_next;
                     MODE_BOUNCE: begin
                        // Turn around at either end so the end LED is lit only once per pass.
                        if (dir_reg == DIR_LEFT) begin
                           if (leds_reg == PAT_MSB) begin
                              leds_next = PAT_MSB >> 1;
                              dir_next  = DIR_RIGHT;
                           end else begin
                              leds_next = leds_reg << 1;
                           end
                        end else begin
                           if (leds_reg == PAT_LSB) begin
                              leds_next = PAT_LSB << 1;
                              dir_next  = DIR_LEFT;
                           end else begin
                              leds_next = leds_reg >> 1;
                           end
                        end
                     end
                     default: leds_next = PAT_OFF;
                  endcase
               end
            end
            PAUSED: begin
               if (!pause) begin
                  state_next = RUN;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         mode_reg  <= MODE_OFF;
         speed_reg <= 2'd0;
         dir_reg   <= DIR_LEFT;
         leds_reg  <= PAT_OFF;
         tick_reg  <= 1'b0;
         ready_reg <= 1'b0;
         busy_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         mode_reg  <= mode_next;
         speed_reg <= speed_next;
         dir_reg   <= dir_next;
         leds_reg  <= leds_next;
         tick_reg  <= tick_next;
         ready_reg <= ready_next;
         busy_reg  <= busy_next;
      end
   end

   assign cmd.cmd_ready = ready_reg;
   assign leds          = leds_reg;
   assign step_tick     = tick_reg;
   assign busy          = busy_reg;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl with BASE = 4 cycles per step: each scenario queues
// the expected outputs for every cycle, then pops and compares them cycle by cycle.
module tb_led_pattern_ctrl;
   import led_ctrl_pkg::*;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       pause = 1'b0;
   logic [7:0] leds;
   logic       step_tick;
   logic       busy;

   led_pattern_ctrl_if cmd_bus ();

   led_pattern_ctrl #(
      .CLK_FREQ (16),
      .STEP_DIV (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd       (cmd_bus),
      .pause     (pause),
      .leds      (leds),
      .step_tick (step_tick),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] leds;
      logic       tick;
      logic       ready;
      logic       busy;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fails  = 0;

   function automatic void expect_cycle(logic [7:0] l, logic t, logic r, logic b);
      exp_q.push_back('{leds: l, tick: t, ready: r, busy: b});
   endfunction

   function automatic logic [7:0] bounce_pat(int k);
      logic [7:0] one;
      int         p;
      one = 8'h01;
      p   = k % 14;
      return (p <= 7) ? (one << p) : (one << (14 - p));
   endfunction

   function automatic logic [7:0] chase_pat(int k);
      logic [7:0] one;
      one = 8'h01;
      return one << (k % 8);
   endfunction

   task automatic test_reset();
      exp_t e;
      int   n;
      rst_n             = 1'b0;
      pause             = 1'b0;
      cmd_bus.cmd_valid = 1'b0;
      cmd_bus.cmd_mode  = MODE_OFF;
      cmd_bus.cmd_speed = 2'd0;
      repeat (2) @(negedge clk);
      expect_cycle(8'h00, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 50; i++) expect_cycle(8'h00, 1'b0, 1'b1, 1'b0);
      n = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks += 4;
         if (leds !== e.leds) begin n_fails++; $display("FAIL reset n=%0d leds actual %h required %h", n, leds, e.leds); end
         if (step_tick !== e.tick) begin n_fails++; $display("FAIL reset n=%0d step_tick actual %b required %b", n, step_tick, e.tick); end
         if (cmd_bus.cmd_ready !== e.ready) begin n_fails++; $display("FAIL reset n=%0d cmd_ready actual %b required %b", n, cmd_bus.cmd_ready, e.ready); end
         if (busy !== e.busy) begin n_fails++; $display("FAIL reset n=%0d busy actual %b required %b", n, busy, e.busy); end
         if (n == 0) rst_n = 1'b1;
         n++;
      end
      $display("reset/idle: %0d cycles compared", n);
   endtask

   task automatic test_chase();
      exp_t e;
      int   n;
      cmd_bus.cmd_valid = 1'b1;
      cmd_bus.cmd_mode  = MODE_CHASE;
      cmd_bus.cmd_speed = 2'd0;
      expect_cycle(8'h01, 1'b0, 1'b0, 1'b1);
      expect_cycle(8'h01, 1'b0, 1'b1, 1'b1);
      for (int i = 2; i <= 37; i++)
         expect_cycle(chase_pat((i - 1) / 4), (i >= 5) && ((i - 1) % 4 == 0), 1'b1, 1'b1);
      n = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks += 4;
         if (leds !== e.leds) begin n_fails++; $display("FAIL chase n=%0d leds actual %h required %h", n, leds, e.leds); end
         if (step_tick !== e.tick) begin n_fails++; $display("FAIL chase n=%0d step_tick actual %b required %b", n, step_tick, e.tick); end
         if (cmd_bus.cmd_ready !== e.ready) begin n_fails++; $display("FAIL chase n=%0d cmd_ready actual %b required %b", n, cmd_bus.cmd_ready, e.ready); end
         if (busy !== e.busy) begin n_fails++; $display("FAIL chase n=%0d busy actual %b required %b", n, busy, e.busy); end
         if (n == 0) cmd_bus.cmd_valid = 1'b0;
         n++;
      end
      $display("chase speed0: %0d cycles compared", n);
   endtask

   task automatic test_bounce();
      exp_t e;
      int   n;
      cmd_bus.cmd_valid = 1'b1;
      cmd_bus.cmd_mode  = MODE_BOUNCE;
      cmd_bus.cmd_speed = 2'd2;
      expect_cycle(8'h01, 1'b0, 1'b0, 1'b1);
      expect_cycle(8'h01, 1'b0, 1'b1, 1'b1);
      for (int i = 2; i <= 17; i++) expect_cycle(bounce_pat(i - 1), 1'b1, 1'b1, 1'b1);
      n = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks += 4;
         if (leds !== e.leds) begin n_fails++; $display("FAIL bounce n=%0d leds actual %h required %h", n, leds, e.leds); end
         if (step_tick !== e.tick) begin n_fails++; $display("FAIL bounce n=%0d step_tick actual %b required %b", n, step_tick, e.tick); end
         if (cmd_bus.cmd_ready !== e.ready) begin n_fails++; $display("FAIL bounce n=%0d cmd_ready actual %b required %b", n, cmd_bus.cmd_ready, e.ready); end
         if (busy !== e.busy) begin n_fails++; $display("FAIL bounce n=%0d busy actual %b required %b", n, busy, e.busy); end
         if (n == 0) cmd_bus.cmd_valid = 1'b0;
         n++;
      end
      $display("bounce speed2: %0d cycles compared", n);
   endtask

   task automatic test_blink_pause();
      exp_t e;
      int   n;
      cmd_bus.cmd_valid = 1'b1;
      cmd_bus.cmd_mode  = MODE_BLINK;
      cmd_bus.cmd_speed = 2'd3;
      expect_cycle(8'hFF, 1'b0, 1'b0, 1'b1);
      expect_cycle(8'hFF, 1'b0, 1'b1, 1'b1);
      for (int i = 2; i <= 4; i++) expect_cycle(((i - 1) % 2 == 1) ? 8'h00 : 8'hFF, 1'b1, 1'b1, 1'b1);
      for (int i = 5; i <= 10; i++) expect_cycle(8'h00, 1'b0, 1'b1, 1'b1);
      for (int i = 11; i <= 14; i++) expect_cycle(((i - 7) % 2 == 1) ? 8'h00 : 8'hFF, 1'b1, 1'b1, 1'b1);
      n = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks += 4;
         if (leds !== e.leds) begin n_fails++; $display("FAIL blink_pause n=%0d leds actual %h required %h", n, leds, e.leds); end
         if (step_tick !== e.tick) begin n_fails++; $display("FAIL blink_pause n=%0d step_tick actual %b required %b", n, step_tick, e.tick); end
         if (cmd_bus.cmd_ready !== e.ready) begin n_fails++; $display("FAIL blink_pause n=%0d cmd_ready actual %b required %b", n, cmd_bus.cmd_ready, e.ready); end
         if (busy !== e.busy) begin n_fails++; $display("FAIL blink_pause n=%0d busy actual %b required %b", n, busy, e.busy); end
         if (n == 0) cmd_bus.cmd_valid = 1'b0;
         if (n == 4) pause = 1'b1;
         if (n == 9) pause = 1'b0;
         n++;
      end
      $display("blink speed3 with pause: %0d cycles compared", n);
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   n;
      cmd_bus.cmd_valid = 1'b1;
      cmd_bus.cmd_mode  = MODE_CHASE;
      cmd_bus.cmd_speed = 2'd0;
      expect_cycle(8'h01, 1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= 8; i++) expect_cycle(chase_pat((i - 1) / 4), (i == 5), 1'b1, 1'b1);
      expect_cycle(8'hFF, 1'b0, 1'b0, 1'b1);
      expect_cycle(8'hFF, 1'b0, 1'b1, 1'b1);
      expect_cycle(8'h01, 1'b0, 1'b0, 1'b1);
      expect_cycle(8'h01, 1'b0, 1'b1, 1'b1);
      expect_cycle(8'h00, 1'b0, 1'b0, 1'b0);
      for (int i = 14; i <= 19; i++) expect_cycle(8'h00, 1'b0, 1'b1, 1'b0);
      n = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks += 4;
         if (leds !== e.leds) begin n_fails++; $display("FAIL collision n=%0d leds actual %h required %h", n, leds, e.leds); end
         if (step_tick !== e.tick) begin n_fails++; $display("FAIL collision n=%0d step_tick actual %b required %b", n, step_tick, e.tick); end
         if (cmd_bus.cmd_ready !== e.ready) begin n_fails++; $display("FAIL collision n=%0d cmd_ready actual %b required %b", n, cmd_bus.cmd_ready, e.ready); end
         if (busy !== e.busy) begin n_fails++; $display("FAIL collision n=%0d busy actual %b required %b", n, busy, e.busy); end
         case (n)
            0:  cmd_bus.cmd_valid = 1'b0;
            8:  begin cmd_bus.cmd_valid = 1'b1; cmd_bus.cmd_mode = MODE_BLINK; cmd_bus.cmd_speed = 2'd0; end
            10: cmd_bus.cmd_mode = MODE_CHASE;
            12: cmd_bus.cmd_mode = MODE_OFF;
            14: cmd_bus.cmd_valid = 1'b0;
            default: ;
         endcase
         n++;
      end
      $display("collision and back-to-back: %0d cycles compared", n);
   endtask

   task automatic test_midrun_reset();
      exp_t e;
      int   n;
      cmd_bus.cmd_valid = 1'b1;
      cmd_bus.cmd_mode  = MODE_BOUNCE;
      cmd_bus.cmd_speed = 2'd0;
      expect_cycle(8'h01, 1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= 18; i++) expect_cycle(bounce_pat((i - 1) / 4), (i >= 5) && ((i - 1) % 4 == 0), 1'b1, 1'b1);
      expect_cycle(8'h00, 1'b0, 1'b0, 1'b0);
      expect_cycle(8'h00, 1'b0, 1'b1, 1'b0);
      expect_cycle(8'h00, 1'b0, 1'b1, 1'b0);
      expect_cycle(8'h01, 1'b0, 1'b0, 1'b1);
      for (int i = 23; i <= 26; i++) expect_cycle(8'h01, 1'b0, 1'b1, 1'b1);
      expect_cycle(8'h02, 1'b1, 1'b1, 1'b1);
      expect_cycle(8'h02, 1'b0, 1'b1, 1'b1);
      n = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks += 4;
         if (leds !== e.leds) begin n_fails++; $display("FAIL midrun_reset n=%0d leds actual %h required %h", n, leds, e.leds); end
         if (step_tick !== e.tick) begin n_fails++; $display("FAIL midrun_reset n=%0d step_tick actual %b required %b", n, step_tick, e.tick); end
         if (cmd_bus.cmd_ready !== e.ready) begin n_fails++; $display("FAIL midrun_reset n=%0d cmd_ready actual %b required %b", n, cmd_bus.cmd_ready, e.ready); end
         if (busy !== e.busy) begin n_fails++; $display("FAIL midrun_reset n=%0d busy actual %b required %b", n, busy, e.busy); end
         case (n)
            0:  cmd_bus.cmd_valid = 1'b0;
            18: begin rst_n = 1'b0; cmd_bus.cmd_valid = 1'b1; cmd_bus.cmd_mode = MODE_BLINK; end
            19: begin rst_n = 1'b1; cmd_bus.cmd_valid = 1'b0; end
            21: begin cmd_bus.cmd_valid = 1'b1; cmd_bus.cmd_mode = MODE_CHASE; cmd_bus.cmd_speed = 2'd0; end
            22: cmd_bus.cmd_valid = 1'b0;
            default: ;
         endcase
         n++;
      end
      $display("mid-run reset and restart: %0d cycles compared", n);
   endtask

   initial begin
      test_reset();
      test_chase();
      test_bounce();
      test_blink_pause();
      test_back_to_back();
      test_midrun_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
- Sequences the 8-bit board LED bank through selectable animation modes: off, blink-all, chase and bounce.
- Generates the step rate internally from the system clock.
- Accepts mode/speed commands over a valid/ready handshake and supports pause/resume.
- Sits between the top-level control logic (buttons/UART command decoder) and the physical LED pins.

Parameters:
- CLK_FREQ, 25_000_000, system clock frequency in Hz.
- STEP_DIV, 4, animation steps per second at speed 0; BASE = CLK_FREQ/STEP_DIV clock cycles per step.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_mode  input  2  0 OFF, 1 BLINK, 2 CHASE, 3 BOUNCE.
- cmd_speed  input  2  step period = BASE >> cmd_speed.
- pause  input  1  level; 1 freezes the animation.
- leds  output  8  LED drive, bit0 = LED0.
- step_tick  output  1  one-cycle pulse in the cycle after each applied animation step.
- busy  output  1  1 when the active mode is not OFF.

Behaviour:
- Clock and reset: reset rst_n, synchronous, active-low; clock clk. All outputs are registered.
- Reset values: leds=8'h00, step_tick=0, cmd_ready=0, busy=0, mode=OFF, speed=0, counter=0, dir=left, state=IDLE.
- Command handshake:
  - Accept when cmd_valid && cmd_ready at a rising edge.
  - cmd_ready is registered. Its next value is 0 if a command is accepted this edge, else 1. It is therefore 1 from the first cycle after reset release and low for exactly one cycle after each accept.
  - Holding cmd_valid high yields one accept every 2 cycles.
- On the accept edge:
  - Latch mode and speed; clear counter; dir=left.
  - Load leds: OFF 00, BLINK FF, CHASE 01, BOUNCE 01.
  - state <= LOAD.
- States:
  - IDLE: mode OFF; counter held at 0; leds=00.
  - LOAD: one-cycle settle; no counting, no tick. Next state is IDLE if mode is OFF, else PAUSED if pause=1, else RUN.
  - RUN: counter increments each cycle. When counter >= period-1, clear counter and apply one step. If pause=1, go to PAUSED; no count or step occurs in that cycle.
  - PAUSED: counter and leds hold. When pause=0, go to RUN; counting resumes from the held value the following cycle.
- Period:
  - period = BASE >> speed, clamped to a minimum of 1.
  - Counter is 32 bits.
  - The first step after LOAD occurs when counter reaches period-1: period cycles after entering RUN.
- Step rules:
  - BLINK: leds = ~leds.
  - CHASE: rotate left; 80 wraps to 01.
  - BOUNCE: one-hot shift in dir.
    - At 80 with dir=left: go to 40, dir=right.
    - At 01 with dir=right: go to 02, dir=left.
    - Cycle length is 14 steps.
- step_tick: 1 for the single cycle after a step is applied; 0 otherwise.
- busy: registered (mode != OFF), updated on the accept edge.
- Simultaneous events:
  - Accept and step due in the same cycle: the command wins; the step and its tick are dropped.
  - Accept while PAUSED: new mode loads, and LOAD returns to PAUSED if pause is still 1.
  - Accept while in LOAD is impossible, because cmd_ready=0.
- Reset mid-operation: all state returns to reset values on the next edge; any in-flight command is discarded.

Decomposition:
- Package led_ctrl_pkg:
  - mode encoding constants: MODE_OFF, MODE_BLINK, MODE_CHASE, MODE_BOUNCE.
  - state encoding: IDLE, LOAD, RUN, PAUSED.
  - initial pattern constants.
  - DIR_LEFT/DIR_RIGHT.
- Sub-module led_step_timer:
  - Inputs: period, enable, clear. Output: tick.
  - Contains the 32-bit counter and the clamp.
  - The FSM and pattern logic stay in led_pattern_ctrl.

Test Plan:
(All scenarios use CLK_FREQ=16, STEP_DIV=4, so BASE=4.)
- Reset then idle: hold rst_n=0 for 3 cycles, release → leds=00, busy=0, cmd_ready=0 in the first cycle and 1 thereafter; no step_tick for 50 cycles.
- CHASE speed 0: accept mode=2, speed=0 → leds=01 immediately; then 02,04,…,80,01 every 4 cycles after RUN entry; each step followed by a 1-cycle step_tick.
- BOUNCE speed 2 (period 1): leds 01,02,…,80,40,…,01,02 stepping every cycle; verify both turnarounds and the 14-step cycle.
- BLINK speed 3 (clamped to period 1) with pause: FF/00 alternate each cycle; hold pause for 5 cycles → leds and step_tick frozen; release → toggling resumes 1 cycle later.
- Handshake collision: command accepted in the same cycle a CHASE step is due → no step_tick, leds = new mode's initial pattern, cmd_ready low for exactly 1 cycle; back-to-back cmd_valid accepted every 2 cycles.
- Mid-run reset: reset asserted during BOUNCE with leds=10 → next edge leds=00, busy=0, cmd_ready=0, state IDLE; a subsequent CHASE command restarts at 01.
